stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
- Dual-mode 8-bit time counter: stopwatch (count up from 0) or countdown timer (count down from a preset).
- A programmable prescaler generates the count tick.
- Sits between a button/CSR front-end (start, mode, timer_set) and a display/interrupt consumer (time_out, done).

Parameters:
- WIDTH, 8, bit width of timer_set and time_out.
- TICK_DIV, 1, clock cycles per count tick (1 = count every clock; must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle command pulse: start/pause/resume/restart.
- mode  input  1  0 = stopwatch (up), 1 = timer (down); sampled only on a launching start.
- timer_set  input  WIDTH  countdown preset; sampled only on a launching start in mode 1.
- time_out  output  WIDTH  current count, registered.
- done  output  1  registered level; high while in DONE.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE.
- Reset (synchronous, highest priority, wins over start): state=IDLE, time_out=0, done=0, prescaler=0, latched mode=0.
- Launching start (start=1 in IDLE or DONE):
  - state->RUN, done->0, prescaler->0.
  - Latch mode.
  - time_out <= timer_set if mode=1, else 0.
  - Takes effect on the same edge start is sampled.
- start=1 in RUN -> PAUSE: count and prescaler hold.
- start=1 in PAUSE -> RUN: resume, no reload; mode and timer_set ignored.
- The mode input is ignored outside a launching start. Changing mode mid-run has no effect.
- Tick generation:
  - In RUN, the prescaler counts 0..TICK_DIV-1.
  - tick=1 on the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
  - With TICK_DIV=1, tick=1 every RUN cycle.
  - The prescaler does not advance in IDLE, PAUSE or DONE.
- Stopwatch (latched mode 0), on tick:
  - time_out+1.
  - If time_out == 2^WIDTH-1 before the increment: hold at max, state->DONE, done=1 (saturate, no wrap).
- Timer (latched mode 1), on tick:
  - time_out-1.
  - When the decrement yields 0: state->DONE and done=1 on the same edge time_out becomes 0.
- timer_set=0 with mode 1:
  - Launching start loads 0.
  - Next edge: state->DONE, done=1 without waiting for a tick.
- Latency, TICK_DIV=1: start sampled at edge k loads the value; edges k+1..k+N step the count. A timer preset of N reaches 0 with done=1 after edge k+N.
- DONE:
  - time_out and done hold until reset or a launching start.
  - Further start pulses with no reset relaunch immediately.
- start held high for several cycles is treated as one pulse per cycle (toggles RUN/PAUSE each cycle). The front-end must deliver one-cycle pulses.
- No combinational input-to-output paths.

Decomposition:
- Shared package stopwatch_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Mode constants MODE_UP=0, MODE_DOWN=1.
- Sub-module stopwatch_tick_gen (parameter TICK_DIV; inputs clk, reset, enable, clear; output tick) implements the prescaler.
- The FSM and counter stay in stopwatch_timer.

Test Plan:
- Stopwatch count-up: reset 1 cycle, mode=0, 1-cycle start, TICK_DIV=1 -> time_out=0 at launch edge, then 1,2,... each clock; 10 clocks after launch time_out=10, done=0.
- Countdown: reset, mode=1, timer_set=10, 1-cycle start -> time_out=10 at launch, decrements each clock, reaches 0 with done=1 10 edges after launch; holds 0/done=1 for 200 ns afterwards.
- Pause/resume: stopwatch launched, at time_out=5 pulse start -> holds 5 for 20 cycles; pulse start again -> continues 6,7,...
- Saturation and zero preset:
  - Stopwatch run for 260 cycles -> time_out sticks at 255 with done=1.
  - Timer with timer_set=0 -> done=1 one edge after launch, time_out=0.
- Reset mid-operation: timer running at time_out=4, assert reset 1 cycle -> next edge time_out=0, done=0, state IDLE; reset and start in the same cycle -> reset wins.
- Prescaler: TICK_DIV=4, timer_set=3 -> time_out steps every 4 clocks; done=1 12 clocks after launch; mode toggled mid-run has no effect.

Source files
------------

// File: rtl/stopwatch_timer_pkg.sv
// Shared types and constants for the stopwatch/countdown timer.
package stopwatch_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler: pulses tick once every TICK_DIV enabled cycles.
module stopwatch_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Dual-mode counter: stopwatch counting up, or timer counting down from a preset.
module stopwatch_timer
    import stopwatch_timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] timer_set,
    output logic [WIDTH-1:0] time_out,
    output logic             done
);

    localparam logic [WIDTH-1:0] TIME_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] time_q, time_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic             launch, tick_en, tick;

    // A start in RUN pauses on that very edge, so the prescaler must not step then.
    assign launch  = start && ((state_q == IDLE) || (state_q == DONE));
    assign tick_en = (state_q == RUN) && !start;

    stopwatch_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .enable(tick_en),
        .clear (launch),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = done_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    mode_d  = mode;
                    time_d  = (mode == MODE_DOWN) ? timer_set : '0;
                end
            end
            RUN: begin
                if (start) begin
                    state_d = PAUSE;
                end else if ((mode_q == MODE_DOWN) && (time_q == '0)) begin
                    // Zero preset finishes without waiting for a tick.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (mode_q == MODE_UP) begin
                        if (time_q == TIME_MAX) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            time_d = time_q + 1'b1;
                        end
                    end else begin
                        time_d = time_q - 1'b1;
                        if (time_q == WIDTH'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= '0;
            done_q  <= 1'b0;
            mode_q  <= MODE_UP;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    assign time_out = time_q;
    assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_stopwatch_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, mode;
    logic [7:0] timer_set;
    logic [7:0] time1;
    logic       done1;
    logic       start4, mode4;
    logic [7:0] set4;
    logic [7:0] time4;
    logic       done4;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(.WIDTH(8), .TICK_DIV(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .timer_set(timer_set),
        .time_out (time1),
        .done     (done1)
    );

    stopwatch_timer #(.WIDTH(8), .TICK_DIV(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start4),
        .mode     (mode4),
        .timer_set(set4),
        .time_out (time4),
        .done     (done4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; timer_set = 8'd0;
        start4 = 1'b0; mode4 = 1'b0; set4 = 8'd0;

        // Reset state
        step();
        chk("rst_time", time1, 0);
        chk("rst_done", done1, 0);
        chk("rst_time4", time4, 0);
        reset = 1'b0;
        step();
        chk("idle_time", time1, 0);

        // Stopwatch count-up
        mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("up_launch", time1, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("up_count", time1, i);
        end
        chk("up_done", done1, 0);

        // Pause / resume
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        chk("pr_at5", time1, 5);
        start = 1'b1; step(); start = 1'b0;
        chk("pr_pause_edge", time1, 5);
        mode = 1'b1; timer_set = 8'd77;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pr_hold", time1, 5);
        end
        start = 1'b1; step(); start = 1'b0;
        chk("pr_resume_edge", time1, 5);
        step(); chk("pr_6", time1, 6);
        step(); chk("pr_7", time1, 7);
        chk("pr_done", done1, 0);

        // Saturation at 255
        reset = 1'b1; step(); reset = 1'b0;
        mode = 1'b0; start = 1'b1; step(); start = 1'b0;
        repeat (255) step();
        chk("sat_255", time1, 255);
        chk("sat_not_done", done1, 0);
        step();
        chk("sat_hold", time1, 255);
        chk("sat_done", done1, 1);
        repeat (4) step();
        chk("sat_hold2", time1, 255);
        chk("sat_done2", done1, 1);

        // Countdown relaunched directly from DONE
        mode = 1'b1; timer_set = 8'd10; start = 1'b1; step(); start = 1'b0;
        chk("dn_launch", time1, 10);
        chk("dn_launch_done", done1, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("dn_count", time1, 10 - i);
            chk("dn_done", done1, (i == 10) ? 1 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            chk("dn_hold_time", time1, 0);
            chk("dn_hold_done", done1, 1);
        end

        // Zero preset
        timer_set = 8'd0; start = 1'b1; step(); start = 1'b0;
        chk("z_launch_time", time1, 0);
        chk("z_launch_done", done1, 0);
        step();
        chk("z_time", time1, 0);
        chk("z_done", done1, 1);

        // Reset mid-operation, then reset beating start
        timer_set = 8'd10; start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        chk("mr_at4", time1, 4);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mr_time", time1, 0);
        chk("mr_done", done1, 0);
        step();
        chk("mr_idle", time1, 0);
        reset = 1'b1; start = 1'b1; timer_set = 8'd9; step();
        reset = 1'b0; start = 1'b0;
        chk("rs_time", time1, 0);
        chk("rs_done", done1, 0);
        step();
        chk("rs_idle", time1, 0);

        // Prescaler, TICK_DIV=4
        mode4 = 1'b1; set4 = 8'd3; start4 = 1'b1; step(); start4 = 1'b0;
        chk("ps_launch", time4, 3);
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) mode4 = 1'b0;
            if (i == 9) mode4 = 1'b1;
            step();
            chk("ps_time", time4, (i >= 12) ? 0 : 3 - i / 4);
            chk("ps_done", done4, (i >= 12) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
